// File: rtl/seg7_pkg.sv
// Shared widths and the hex-to-seven-segment table for the scanned display driver.
package seg7_pkg;

  localparam int unsigned SEG_W = 7;

  // Counter width for a modulus n; a modulus of 1 still needs one bit of storage.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Active-high gfedcba pattern for one hex nibble.
  function automatic logic [SEG_W-1:0] hex7(input logic [3:0] nib);
    logic [SEG_W-1:0] s;
    case (nib)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      4'hF: s = 7'h71;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational 4-bit to 7-segment decode, active-high, bit order gfedcba.
module seg7_hex_decoder
  import seg7_pkg::*;
(
  input  logic [3:0]       nibble_i,
  output logic [SEG_W-1:0] segs_o
);

  // Table lookup for the currently selected nibble.
  always_comb begin
    segs_o = hex7(nibble_i);
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// N-digit multiplexed 7-segment driver: prescaled digit scan, blank gap per slot,
// leading-zero suppression and frame-aligned display updates.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int N_DIGITS       = 4,
  parameter int CLK_DIV        = 50000,
  parameter int BLANK_CYCLES   = 1,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst_n,
  input  logic [4*N_DIGITS-1:0] i_Valor,
  input  logic                  i_Load,
  input  logic                  i_Enable,
  input  logic                  i_Blank_Zeros,
  output logic [SEG_W-1:0]      o_Segmentos,
  output logic [N_DIGITS-1:0]   o_Digitos,
  output logic                  o_Scan_Done
);

  localparam int PRE_W  = cnt_width(CLK_DIV);
  localparam int PRE_W1 = PRE_W + 1;
  localparam int IDX_W  = cnt_width(N_DIGITS);
  localparam int VAL_W  = 4 * N_DIGITS;

  localparam logic [PRE_W-1:0]    PRE_MAX   = PRE_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0]    IDX_MAX   = IDX_W'(N_DIGITS - 1);
  localparam logic [PRE_W1-1:0]   BLANK_LIM = PRE_W1'(BLANK_CYCLES);
  localparam logic [SEG_W-1:0]    SEG_OFF   = (SEG_ACTIVE_LOW != 0) ? {SEG_W{1'b1}} : {SEG_W{1'b0}};
  localparam logic [N_DIGITS-1:0] DIG_OFF   = (DIG_ACTIVE_LOW != 0) ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};

  if (N_DIGITS < 1 || N_DIGITS > 8) begin : g_bad_digits
    $error("seg7_scan_driver: N_DIGITS must be in 1..8");
  end
  if (CLK_DIV < 2) begin : g_bad_div
    $error("seg7_scan_driver: CLK_DIV must be at least 2");
  end
  if (BLANK_CYCLES < 0 || BLANK_CYCLES >= CLK_DIV) begin : g_bad_blank
    $error("seg7_scan_driver: BLANK_CYCLES must be in 0..CLK_DIV-1");
  end

  logic [PRE_W-1:0]    presc_q, presc_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [VAL_W-1:0]    hold_q, hold_d;
  logic [VAL_W-1:0]    disp_q, disp_d;
  logic                done_q, done_d;
  logic [SEG_W-1:0]    seg_q, seg_d;
  logic [N_DIGITS-1:0] dig_q, dig_d;

  logic                wrap_s;
  logic                frame_s;
  logic                blank_s;
  logic [3:0]          nibble_s;
  logic [SEG_W-1:0]    dec_segs_s;
  logic [N_DIGITS-1:0] onehot_s;
  logic                suppress_s;
  logic [SEG_W-1:0]    seg_raw_s;
  logic [N_DIGITS-1:0] dig_raw_s;

  seg7_hex_decoder u_dec (
    .nibble_i (nibble_s),
    .segs_o   (dec_segs_s)
  );

  // Scan counters and the holding/display registers; display only moves at a frame boundary.
  always_comb begin
    wrap_s  = (presc_q == PRE_MAX);
    frame_s = wrap_s && (idx_q == IDX_MAX);
    presc_d = wrap_s ? {PRE_W{1'b0}} : (presc_q + PRE_W'(1));
    idx_d   = idx_q;
    if (wrap_s) begin
      if (idx_q == IDX_MAX) begin
        idx_d = {IDX_W{1'b0}};
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end else begin
      idx_d = idx_q;
    end
    hold_d = i_Load ? i_Valor : hold_q;
    // hold_d already carries the same-cycle load, which gives the boundary bypass.
    disp_d = frame_s ? hold_d : disp_q;
    done_d = frame_s;
  end

  // Digit select, leading-zero suppression and polarity for the next output register value.
  always_comb begin
    nibble_s   = 4'h0;
    onehot_s   = {N_DIGITS{1'b0}};
    suppress_s = 1'b0;
    blank_s    = ({1'b0, presc_q} < BLANK_LIM);
    for (int k = 0; k < N_DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        nibble_s    = disp_q[4*k +: 4];
        onehot_s[k] = 1'b1;
        suppress_s  = i_Blank_Zeros && (k != 0) && ((disp_q >> (4*k)) == {VAL_W{1'b0}});
      end else begin
        onehot_s[k] = 1'b0;
      end
    end
    if (blank_s || !i_Enable) begin
      seg_raw_s = {SEG_W{1'b0}};
      dig_raw_s = {N_DIGITS{1'b0}};
    end else begin
      seg_raw_s = suppress_s ? {SEG_W{1'b0}} : dec_segs_s;
      dig_raw_s = onehot_s;
    end
    seg_d = (SEG_ACTIVE_LOW != 0) ? ~seg_raw_s : seg_raw_s;
    dig_d = (DIG_ACTIVE_LOW != 0) ? ~dig_raw_s : dig_raw_s;
  end

  // State and output registers; reset forces the pins to their inactive levels at once.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      presc_q <= {PRE_W{1'b0}};
      idx_q   <= {IDX_W{1'b0}};
      hold_q  <= {VAL_W{1'b0}};
      disp_q  <= {VAL_W{1'b0}};
      done_q  <= 1'b0;
      seg_q   <= SEG_OFF;
      dig_q   <= DIG_OFF;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      disp_q  <= disp_d;
      done_q  <= done_d;
      seg_q   <= seg_d;
      dig_q   <= dig_d;
    end
  end

  assign o_Segmentos = seg_q;
  assign o_Digitos   = dig_q;
  assign o_Scan_Done = done_q;

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Time-multiplexed driver for an N-digit common-anode/cathode 7-segment display. It is the parametrised successor to the single-digit binary-to-7-segment decoder. It latches a packed hex value, scans one digit at a time at a prescaled rate, and inserts a per-digit anti-ghosting blank gap. It also provides optional leading-zero suppression and tear-free frame-boundary updates. It sits between the system's counter/ALU registers and the board's segment/digit pins.

Parameters:
N_DIGITS, 4, number of digits scanned (1..8).
CLK_DIV, 50000, clock cycles per digit slot (>=2).
BLANK_CYCLES, 1, cycles at start of each slot with all outputs inactive (0..CLK_DIV-1).
SEG_ACTIVE_LOW, 0, 1 = o_Segmentos inverted (common anode).
DIG_ACTIVE_LOW, 1, 1 = o_Digitos inverted.

Ports:
i_Clk  in  1  system clock, all logic on rising edge.
i_Rst_n  in  1  asynchronous active-low reset.
i_Valor  in  4*N_DIGITS  packed hex digits, [3:0] = digit 0 (least significant).
i_Load  in  1  capture i_Valor into holding register this cycle.
i_Enable  in  1  0 = all segments and digits inactive (scan continues).
i_Blank_Zeros  in  1  1 = suppress leading zeros.
o_Segmentos  out  7  segment drive, bit order [6:0] = g,f,e,d,c,b,a.
o_Digitos  out  N_DIGITS  one-hot digit enable, bit k = digit k.
o_Scan_Done  out  1  one-cycle pulse when digit index wraps N_DIGITS-1 -> 0.

Behaviour:
- Reset (async assert, sync release):
  - prescaler = 0, index = 0, holding = 0, display = 0, o_Scan_Done = 0.
  - o_Segmentos and o_Digitos at inactive levels: all 0 before polarity inversion.
- Prescaler counts 0..CLK_DIV-1 and wraps. When it is at CLK_DIV-1, index increments modulo N_DIGITS. A digit slot is exactly CLK_DIV cycles.
- Frame boundary is the cycle in which index goes N_DIGITS-1 -> 0. In that cycle:
  - display <= holding, and o_Scan_Done = 1 (registered).
  - If i_Load is also high, display <= i_Valor directly (bypass) and holding <= i_Valor.
- i_Load otherwise updates holding only. The displayed value never changes mid-frame.
- Outputs are registered, one cycle after the counter state they decode. Pre-inversion:
  - Blank slot (prescaler < BLANK_CYCLES) or i_Enable = 0 -> digits = 0, segs = 0.
  - Otherwise digits = one-hot(index) and segs = hex7(display nibble[index]).
  - Suppressed digit -> its digit bit stays asserted and segs = 0.
- hex7 encoding (active-high, gfedcba):
  - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07
  - 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71
- Leading-zero suppression, when i_Blank_Zeros = 1:
  - Digit k>0 is suppressed iff nibbles k..N_DIGITS-1 of display are all 0.
  - Digit 0 is never suppressed; value 0 shows a single "0".
- Polarity: o_Segmentos = SEG_ACTIVE_LOW ? ~segs : segs. o_Digitos = DIG_ACTIVE_LOW ? ~digits : digits.
- i_Enable has no effect on counters, o_Scan_Done or register loading.
- Reset mid-scan: outputs go inactive immediately (async). Scan restarts at digit 0 slot, cycle 0.
- Elaboration error if CLK_DIV<2, BLANK_CYCLES>=CLK_DIV, or N_DIGITS outside 1..8.

Decomposition:
- Package seg7_pkg:
  - hex7 function/constant table (16 x 7 bits).
  - SEG_W=7.
  - clog2-based widths for prescaler and index.
- Sub-module seg7_hex_decoder: combinational 4-bit -> 7-bit active-high decode, instanced once on the selected nibble.
- Counters, suppression and output registers live in the top module.

Test Plan:
Common setup for all scenarios: N_DIGITS=4, CLK_DIV=4, BLANK_CYCLES=1, SEG_ACTIVE_LOW=0, DIG_ACTIVE_LOW=1.
1. Reset, then release; sample for 16 cycles -> o_Digitos cycles 1111 (blank), 1110 x3, 1111, 1101 x3, ..., with o_Segmentos=3F when active. o_Scan_Done pulses once at cycle 16.
2. i_Load=1 with i_Valor=16'h1234 one cycle after reset -> still 0000 until first o_Scan_Done. Next frame shows digit0=66, digit1=4F, digit2=5B, digit3=06.
3. i_Valor=16'hABCD loaded mid-frame, then 16'hEF01 loaded in the frame-boundary cycle -> next frame shows EF01 (bypass): 06,3F,71,79. ABCD is never displayed.
4. i_Blank_Zeros=1, display 16'h0050 -> digit0=3F, digit1=6D, digit2=00, digit3=00, all digit enables asserted. Value 16'h0000 -> digit0=3F, others 00.
5. i_Enable=0 for one full frame -> o_Digitos=1111, o_Segmentos=00 throughout. o_Scan_Done still pulses every 16 cycles.
6. Assert i_Rst_n=0 asynchronously mid-slot of digit 2 -> outputs inactive the same instant without a clock edge. After release, scan resumes at digit 0 with display=0.
